// File: rtl/br_pkg.sv
// Shared definitions for the branch sequencer: opcode and state encodings,
// the memory-wait timeout, and the routing decision for accepted branches.
package br_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_BMN   = 3'b001,
    OP_BRZ   = 3'b010,
    OP_BZ    = 3'b011,
    OP_JMOR  = 3'b100,
    OP_JALM  = 3'b101,
    OP_JSPAL = 3'b110,
    OP_RSVD  = 3'b111
  } br_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MREQ   = 2'd1,
    ST_COMMIT = 2'd2
  } br_state_t;

  localparam logic [3:0] TIMEOUT = 4'd15;

  // True when the branch target has to be fetched from data memory.
  function automatic logic needs_mem(input br_op_t op, input logic n);
    case (op)
      OP_JMOR, OP_JALM, OP_JSPAL: needs_mem = 1'b1;
      OP_BMN:                     needs_mem = n;
      default:                    needs_mem = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/br_sequencer_if.sv
// Data-memory read handshake used by the branch sequencer for indirect targets.
interface br_sequencer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
  modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/br_wait_ctr.sv
// Wait counter for the memory-request state; saturates at TIMEOUT.
module br_wait_ctr
  import br_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic at_limit
);

  logic [3:0] count;

  // Count cycles without acknowledge; cleared whenever the request is not active.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != TIMEOUT)) begin
      count <= count + 4'd1;
    end
  end

  assign at_limit = (count == TIMEOUT);

endmodule

// File: rtl/br_sequencer.sv
// Branch/jump sequencer: accepts a decoded branch, optionally fetches an
// indirect target from data memory, then commits the next PC for one cycle.
module br_sequencer
  import br_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  br_valid,
  input  logic [2:0]            br_op,
  input  logic                  n,
  input  logic                  z,
  input  logic [31:0]           pc_plus4,
  input  logic [31:0]           reg_s,
  input  logic [31:0]           j_diraddr,
  input  logic [31:0]           ind_addr,
  br_sequencer_if.master        mem,
  output logic                  pc_we,
  output logic [31:0]           next_pc,
  output logic                  link_we,
  output logic [31:0]           link_data,
  output logic                  stall,
  output logic                  br_done,
  output logic                  err
);

  br_state_t   state, state_nxt;
  br_op_t      op_q;
  logic        n_q, z_q;
  logic        tmo_q;
  logic [31:0] target_q;
  logic [31:0] addr_q;
  logic        accept;
  logic        at_limit;
  logic        in_mreq;

  assign in_mreq = (state == ST_MREQ);

  br_wait_ctr u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .clear    (!in_mreq),
    .enable   (in_mreq && !mem.mem_ack),
    .at_limit (at_limit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; an ack in the limit cycle takes priority over timeout.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (br_valid) begin
          accept    = 1'b1;
          state_nxt = needs_mem(br_op_t'(br_op), n) ? ST_MREQ : ST_COMMIT;
        end
      end
      ST_MREQ: begin
        if (mem.mem_ack || at_limit) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Capture op/flags/address at accept and the resolved target in MREQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_NONE;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      tmo_q    <= 1'b0;
      target_q <= '0;
      addr_q   <= '0;
    end else if (accept) begin
      op_q     <= br_op_t'(br_op);
      n_q      <= n;
      z_q      <= z;
      tmo_q    <= 1'b0;
      addr_q   <= ind_addr;
    end else if (in_mreq) begin
      if (mem.mem_ack) begin
        target_q <= mem.mem_rdata;
      end else if (at_limit) begin
        target_q <= pc_plus4;
        tmo_q    <= 1'b1;
      end
    end
  end

  // Output decode; everything except stall/mem is confined to COMMIT.
  always_comb begin
    pc_we        = 1'b0;
    br_done      = 1'b0;
    err          = 1'b0;
    link_we      = 1'b0;
    link_data    = '0;
    next_pc      = '0;
    mem.mem_req  = in_mreq;
    mem.mem_addr = in_mreq ? addr_q : '0;
    stall        = ((state == ST_IDLE) && br_valid) || in_mreq;
    if (state == ST_COMMIT) begin
      pc_we   = 1'b1;
      br_done = 1'b1;
      err     = tmo_q || (op_q == OP_RSVD);
      case (op_q)
        OP_BMN:                     next_pc = n_q ? target_q : pc_plus4;
        OP_BRZ:                     next_pc = z_q ? reg_s : pc_plus4;
        OP_BZ:                      next_pc = z_q ? j_diraddr : pc_plus4;
        OP_JMOR, OP_JALM, OP_JSPAL: next_pc = target_q;
        default:                    next_pc = pc_plus4;
      endcase
      if ((op_q == OP_JALM) || (op_q == OP_JSPAL)) begin
        link_we   = 1'b1;
        link_data = pc_plus4;
      end
    end
  end

endmodule

// File: doc/br_sequencer.md
BR_SEQUENCER -- requirements
Module: br_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port br_valid, input, 1 bit: a decoded branch/jump is present; the source holds it and all operands stable until br_done.
REQ-004 The block SHALL have port br_op, input, 3 bits: 000 none, 001 bmn, 010 brz, 011 bz, 100 jmor, 101 jalm, 110 jspal, 111 reserved.
REQ-005 The block SHALL have ports n and z, inputs, 1 bit each: status flags.
REQ-006 The block SHALL have ports pc_plus4, reg_s, j_diraddr and ind_addr, inputs, 32 bits each: fall-through PC, register target, direct target, and memory-indirect address.
REQ-007 The block SHALL have ports mem_req (output, 1), mem_addr (output, 32), mem_rdata (input, 32) and mem_ack (input, 1): data-memory read handshake.
REQ-008 The block SHALL have ports pc_we (output, 1) and next_pc (output, 32): PC register update.
REQ-009 The block SHALL have ports link_we (output, 1) and link_data (output, 32): link-register write for jalm and jspal.
REQ-010 The block SHALL have outputs stall, br_done and err, 1 bit each: hold the fetch; branch complete (1-cycle pulse); error (1-cycle pulse, concurrent with br_done).

Function
REQ-011 The FSM SHALL have the states IDLE, MREQ and COMMIT.
REQ-012 In IDLE with br_valid=1, the block SHALL capture br_op, n and z (accept cycle); later flag changes SHALL be ignored.
REQ-013 After accept, ops 000, 010, 011, 111, and 001 with captured n=0, SHALL go directly to COMMIT (latency: commit 1 cycle after accept).
REQ-014 After accept, ops 100, 101, 110, and 001 with captured n=1, SHALL go to MREQ.
REQ-015 In MREQ, mem_req SHALL be 1 and mem_addr SHALL equal ind_addr held constant; on mem_ack=1 the block SHALL register mem_rdata as the target and go to COMMIT.
REQ-016 mem_ack outside MREQ SHALL be ignored.
REQ-017 In MREQ, a 4-bit wait counter SHALL start at 0 on entry and increment each cycle without ack.
REQ-018 If ack is still absent with the wait counter at 15, the block SHALL go to COMMIT with target pc_plus4 and err=1; an ack in that same cycle wins over the timeout.
REQ-019 COMMIT SHALL last exactly 1 cycle with pc_we=1 and br_done=1, then go to IDLE.
REQ-020 next_pc in COMMIT SHALL be: bmn taken → mem target; bmn not taken → pc_plus4; brz → reg_s if z else pc_plus4; bz → j_diraddr if z else pc_plus4; jmor/jalm/jspal → mem target; 000 → pc_plus4; 111 → pc_plus4 with err=1.
REQ-021 link_we SHALL be 1 in COMMIT for jalm/jspal only, with link_data=pc_plus4, including on timeout.
REQ-022 stall SHALL equal (IDLE & br_valid) | MREQ, and SHALL be 0 in COMMIT.
REQ-023 Outside COMMIT, pc_we, link_we, br_done and err SHALL be 0.
REQ-024 The block SHALL NOT accept a new branch in the COMMIT cycle; br_valid held after COMMIT is a new branch.

Reset
REQ-025 When reset=1 the block SHALL enter IDLE, clear the wait counter and captured op/flags/target, and drive every output to 0 (next_pc, mem_addr, link_data = 32'h0) in the following cycle.
REQ-026 Reset SHALL override all other inputs, including mid-MREQ and in COMMIT; an aborted branch SHALL produce no pc_we, link_we or br_done.

Structure
REQ-027 A shared package br_pkg SHALL hold the br_op encodings, the FSM state encoding and the constant TIMEOUT=15.
REQ-028 The wait counter SHALL be the sub-module br_wait_ctr (clear/enable/at-limit outputs); everything else SHALL be flat.

Verification
REQ-029 The bench SHALL check: bz, z=1, j_diraddr=32'h0000_0040 → COMMIT on cycle 2, next_pc=32'h40, pc_we=1, stall high 1 cycle.
REQ-030 The bench SHALL check: jalm, ind_addr=32'h100, ack after 3 cycles with rdata=32'h0000_0200, pc_plus4=32'h14 → next_pc=32'h200, link_we=1, link_data=32'h14.
REQ-031 The bench SHALL check: bmn, n=0 at accept then n=1 → no mem_req, next_pc=pc_plus4.
REQ-032 The bench SHALL check: jmor with no ack for 16 MREQ cycles → err=1, next_pc=pc_plus4; then a late ack is ignored.
REQ-033 The bench SHALL check: reset asserted in the 2nd MREQ cycle → IDLE, all outputs 0, no br_done.
REQ-034 The bench SHALL check: br_op=111 → err=1, next_pc=pc_plus4, no mem_req.
